// File: rtl/memory_access_if.sv
// memory_access_if -- data-memory bus between the Y86-64 memory stage and
// the data memory.
//
// Signals (names are from the memory stage's point of view):
//   dmem_req_o    request held high for the whole access
//   dmem_we_o     1 = write, 0 = read
//   dmem_addr_o   access address
//   dmem_wdata_o  write data (0 on reads)
//   dmem_ack_i    access complete
//   dmem_err_i    access faulted, qualified by dmem_ack_i
//   dmem_rdata_i  read data, qualified by dmem_ack_i
//
// Modports: master = memory stage, slave = data memory.
interface memory_access_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic        dmem_err_i;
  logic [63:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_err_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    output dmem_ack_i, dmem_err_i, dmem_rdata_i
  );
endinterface

// File: rtl/memory_access.sv
// memory_access -- Y86-64 memory stage.
//
// Accepts one instruction at a time from execute. Memory ops (rmmovq, pushq,
// call, mrmovq, ret, popq) issue a single request on the data-memory bus and
// wait for an ack or a timeout. Everything else retires the cycle after
// acceptance. Each accepted instruction produces one wb_valid_o pulse.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   valid_i / ready_o   accept handshake (ready_o high only in IDLE)
//   icode_i             instruction code
//   valE_i, valA_i,
//   valP_i              ALU result, register A, next PC
//   dmem                data-memory bus (master modport)
//   wb_valid_o          one-cycle retire pulse
//   valE_o, valM_o      results for writeback (held between pulses)
//   dmem_error_o        retired instruction faulted or timed out
module memory_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [3:0]            icode_i,
  input  logic [63:0]           valE_i,
  input  logic [63:0]           valA_i,
  input  logic [63:0]           valP_i,
  memory_access_if.master       dmem,
  output logic                  wb_valid_o,
  output logic [63:0]           valE_o,
  output logic [63:0]           valM_o,
  output logic                  dmem_error_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [4:0] TMO = 5'(TIMEOUT_CYCLES);

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  function automatic logic is_write(input logic [3:0] ic);
    return (ic == I_RMMOVQ) || (ic == I_PUSHQ) || (ic == I_CALL);
  endfunction

  function automatic logic is_read(input logic [3:0] ic);
    return (ic == I_MRMOVQ) || (ic == I_RET) || (ic == I_POPQ);
  endfunction

  // ret/popq address through the stack pointer in valA; the rest use valE.
  function automatic logic [63:0] mem_addr(input logic [3:0]  ic,
                                           input logic [63:0] e,
                                           input logic [63:0] a);
    return ((ic == I_RET) || (ic == I_POPQ)) ? a : e;
  endfunction

  // call pushes the return address; rmmovq/pushq store valA; reads drive 0.
  function automatic logic [63:0] mem_wdata(input logic [3:0]  ic,
                                            input logic [63:0] a,
                                            input logic [63:0] p);
    if (ic == I_CALL)   return p;
    if (is_write(ic))   return a;
    return 64'd0;
  endfunction

  logic [0:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  cnt_inc;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] vale_lat_q, vale_lat_d;
  logic        wbv_q, wbv_d;
  logic [63:0] vale_q, vale_d;
  logic [63:0] valm_q, valm_d;
  logic        err_q, err_d;

  assign cnt_inc = cnt_q + 5'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    vale_lat_d = vale_lat_q;
    wbv_d      = 1'b0;
    vale_d     = vale_q;
    valm_d     = valm_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (is_write(icode_i) || is_read(icode_i)) begin
            state_d    = BUSY;
            cnt_d      = 5'd0;
            req_d      = 1'b1;
            we_d       = is_write(icode_i);
            addr_d     = mem_addr(icode_i, valE_i, valA_i);
            wdata_d    = mem_wdata(icode_i, valA_i, valP_i);
            vale_lat_d = valE_i;
          end else begin
            wbv_d  = 1'b1;
            vale_d = valE_i;
            valm_d = 64'd0;
            err_d  = 1'b0;
          end
        end
      end
      default: begin
        // Ack is checked first so an ack on the timeout cycle still wins.
        if (dmem.dmem_ack_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
          wbv_d   = 1'b1;
          vale_d  = vale_lat_q;
          valm_d  = (!we_q && !dmem.dmem_err_i) ? dmem.dmem_rdata_i : 64'd0;
          err_d   = dmem.dmem_err_i;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO) begin
            state_d = IDLE;
            req_d   = 1'b0;
            wbv_d   = 1'b1;
            vale_d  = vale_lat_q;
            valm_d  = 64'd0;
            err_d   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      wbv_q   <= 1'b0;
      vale_q  <= 64'd0;
      valm_q  <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wbv_q   <= wbv_d;
      vale_q  <= vale_d;
      valm_q  <= valm_d;
      err_q   <= err_d;
    end
  end

  // Internal copy of valE only feeds outputs through the retire path,
  // so it needs no reset.
  always_ff @(posedge clk_i) begin
    vale_lat_q <= vale_lat_d;
  end

  assign ready_o           = (state_q == IDLE);
  assign dmem.dmem_req_o   = req_q;
  assign dmem.dmem_we_o    = we_q;
  assign dmem.dmem_addr_o  = addr_q;
  assign dmem.dmem_wdata_o = wdata_q;
  assign wb_valid_o        = wbv_q;
  assign valE_o            = vale_q;
  assign valM_o            = valm_q;
  assign dmem_error_o      = err_q;

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access -- directed bench for memory_access.
module tb_memory_access;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  icode_i;
  logic [63:0] valE_i, valA_i, valP_i;
  logic        wb_valid_o;
  logic [63:0] valE_o, valM_o;
  logic        dmem_error_o;

  int errors = 0;
  int checks = 0;

  memory_access_if dbus ();

  memory_access #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .icode_i      (icode_i),
    .valE_i       (valE_i),
    .valA_i       (valA_i),
    .valP_i       (valP_i),
    .dmem         (dbus),
    .wb_valid_o   (wb_valid_o),
    .valE_o       (valE_o),
    .valM_o       (valM_o),
    .dmem_error_o (dmem_error_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b1; icode_i = 4'h6; valE_i = 64'h77;
    valA_i = 64'h0; valP_i = 64'h0;
    dbus.dmem_ack_i = 1'b0; dbus.dmem_err_i = 1'b0; dbus.dmem_rdata_i = 64'h0;
    tick(); tick();
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", ready_o); end
    checks++; if (dbus.dmem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", dbus.dmem_req_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL rst_wbv got=%b exp=0", wb_valid_o); end
    checks++; if ({dbus.dmem_addr_o, dbus.dmem_wdata_o, valE_o, valM_o} !== 256'd0) begin errors++; $display("FAIL rst_data got addr=%h wd=%h e=%h m=%h exp=0", dbus.dmem_addr_o, dbus.dmem_wdata_o, valE_o, valM_o); end
    checks++; if ({dbus.dmem_we_o, dmem_error_o} !== 2'b00) begin errors++; $display("FAIL rst_flags got we=%b err=%b exp=0", dbus.dmem_we_o, dmem_error_o); end
    rst_i = 1'b0; valid_i = 1'b0;
    tick();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid_not_accepted got=%b exp=0", wb_valid_o); end
  endtask

  task automatic test_nonmem();
    valid_i = 1'b1; icode_i = 4'h6; valE_i = 64'h2A;
    tick();
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL nm_wbv got=%b exp=1", wb_valid_o); end
    checks++; if (valE_o !== 64'h2A) begin errors++; $display("FAIL nm_valE got=%h exp=2a", valE_o); end
    checks++; if (valM_o !== 64'h0 || dmem_error_o !== 1'b0) begin errors++; $display("FAIL nm_valM got=%h err=%b exp=0", valM_o, dmem_error_o); end
    checks++; if (dbus.dmem_req_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL nm_req_ready got req=%b rdy=%b exp 0/1", dbus.dmem_req_o, ready_o); end
    icode_i = 4'h3; valE_i = 64'h55;
    tick();
    checks++; if (wb_valid_o !== 1'b1 || valE_o !== 64'h55) begin errors++; $display("FAIL nm_b2b got wbv=%b e=%h exp 1/55", wb_valid_o, valE_o); end
    valid_i = 1'b0;
    tick();
    checks++; if (wb_valid_o !== 1'b0 || valE_o !== 64'h55) begin errors++; $display("FAIL nm_hold got wbv=%b e=%h exp 0/55", wb_valid_o, valE_o); end
  endtask

  task automatic test_ack_idle();
    dbus.dmem_ack_i = 1'b1; dbus.dmem_rdata_i = 64'h99;
    tick();
    dbus.dmem_ack_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b0 || valM_o !== 64'h0) begin errors++; $display("FAIL idle_ack got wbv=%b m=%h exp 0/0", wb_valid_o, valM_o); end
  endtask

  task automatic test_mrmovq();
    valid_i = 1'b1; icode_i = 4'h5; valE_i = 64'h100; valA_i = 64'h999; valP_i = 64'h10;
    tick();
    icode_i = 4'h6; valE_i = 64'h3;
    for (int i = 0; i < 3; i++) begin
      checks++; if (dbus.dmem_req_o !== 1'b1 || dbus.dmem_we_o !== 1'b0 || dbus.dmem_addr_o !== 64'h100 || dbus.dmem_wdata_o !== 64'h0) begin errors++; $display("FAIL mr_bus%0d got req=%b we=%b a=%h wd=%h exp 1/0/100/0", i, dbus.dmem_req_o, dbus.dmem_we_o, dbus.dmem_addr_o, dbus.dmem_wdata_o); end
      checks++; if (ready_o !== 1'b0 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL mr_busy%0d got rdy=%b wbv=%b exp 0/0", i, ready_o, wb_valid_o); end
      if (i == 2) begin
        valid_i = 1'b0; dbus.dmem_ack_i = 1'b1; dbus.dmem_rdata_i = 64'hDEADBEEF;
      end
      tick();
    end
    dbus.dmem_ack_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b1 || valM_o !== 64'hDEADBEEF || valE_o !== 64'h100 || dmem_error_o !== 1'b0) begin errors++; $display("FAIL mr_retire got wbv=%b m=%h e=%h err=%b exp 1/deadbeef/100/0", wb_valid_o, valM_o, valE_o, dmem_error_o); end
    checks++; if (dbus.dmem_req_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL mr_idle got req=%b rdy=%b exp 0/1", dbus.dmem_req_o, ready_o); end
    tick();
    checks++; if (wb_valid_o !== 1'b0 || valM_o !== 64'hDEADBEEF) begin errors++; $display("FAIL mr_pulse got wbv=%b m=%h exp 0/deadbeef", wb_valid_o, valM_o); end
  endtask

  task automatic test_call();
    valid_i = 1'b1; icode_i = 4'h8; valE_i = 64'h1F8; valA_i = 64'h77; valP_i = 64'h40;
    tick();
    valid_i = 1'b0;
    checks++; if (dbus.dmem_req_o !== 1'b1 || dbus.dmem_we_o !== 1'b1 || dbus.dmem_addr_o !== 64'h1F8 || dbus.dmem_wdata_o !== 64'h40) begin errors++; $display("FAIL call_bus got req=%b we=%b a=%h wd=%h exp 1/1/1f8/40", dbus.dmem_req_o, dbus.dmem_we_o, dbus.dmem_addr_o, dbus.dmem_wdata_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL call_early got wbv=%b exp 0", wb_valid_o); end
    dbus.dmem_ack_i = 1'b1; dbus.dmem_rdata_i = 64'h5555;
    tick();
    dbus.dmem_ack_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b1 || valE_o !== 64'h1F8 || valM_o !== 64'h0 || dmem_error_o !== 1'b0) begin errors++; $display("FAIL call_retire got wbv=%b e=%h m=%h err=%b exp 1/1f8/0/0", wb_valid_o, valE_o, valM_o, dmem_error_o); end
  endtask

  task automatic test_fault();
    valid_i = 1'b1; icode_i = 4'hB; valE_i = 64'h208; valA_i = 64'h200;
    tick();
    valid_i = 1'b0;
    checks++; if (dbus.dmem_addr_o !== 64'h200 || dbus.dmem_we_o !== 1'b0) begin errors++; $display("FAIL pop_bus got a=%h we=%b exp 200/0", dbus.dmem_addr_o, dbus.dmem_we_o); end
    dbus.dmem_ack_i = 1'b1; dbus.dmem_err_i = 1'b1; dbus.dmem_rdata_i = 64'h1234;
    tick();
    dbus.dmem_ack_i = 1'b0; dbus.dmem_err_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b1 || dmem_error_o !== 1'b1 || valM_o !== 64'h0 || valE_o !== 64'h208) begin errors++; $display("FAIL pop_fault got wbv=%b err=%b m=%h e=%h exp 1/1/0/208", wb_valid_o, dmem_error_o, valM_o, valE_o); end
  endtask

  task automatic test_timeout();
    valid_i = 1'b1; icode_i = 4'h4; valE_i = 64'h300; valA_i = 64'hAB;
    tick();
    valid_i = 1'b0;
    checks++; if (dbus.dmem_we_o !== 1'b1 || dbus.dmem_wdata_o !== 64'hAB || dbus.dmem_addr_o !== 64'h300) begin errors++; $display("FAIL to_bus got we=%b wd=%h a=%h exp 1/ab/300", dbus.dmem_we_o, dbus.dmem_wdata_o, dbus.dmem_addr_o); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (dbus.dmem_req_o !== 1'b1 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL to_wait%0d got req=%b wbv=%b exp 1/0", i, dbus.dmem_req_o, wb_valid_o); end
      tick();
    end
    checks++; if (dbus.dmem_req_o !== 1'b0 || wb_valid_o !== 1'b1 || dmem_error_o !== 1'b1 || valM_o !== 64'h0 || ready_o !== 1'b1) begin errors++; $display("FAIL to_retire got req=%b wbv=%b err=%b m=%h rdy=%b exp 0/1/1/0/1", dbus.dmem_req_o, wb_valid_o, dmem_error_o, valM_o, ready_o); end
    dbus.dmem_ack_i = 1'b1; dbus.dmem_rdata_i = 64'hBAD;
    tick();
    dbus.dmem_ack_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b0 || ready_o !== 1'b1 || dmem_error_o !== 1'b1) begin errors++; $display("FAIL to_late_ack got wbv=%b rdy=%b err=%b exp 0/1/1", wb_valid_o, ready_o, dmem_error_o); end
  endtask

  task automatic test_ack_at_timeout();
    valid_i = 1'b1; icode_i = 4'h5; valE_i = 64'h600; valA_i = 64'h0;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (dbus.dmem_req_o !== 1'b1) begin errors++; $display("FAIL tp_req16 got=%b exp 1", dbus.dmem_req_o); end
    dbus.dmem_ack_i = 1'b1; dbus.dmem_rdata_i = 64'hCAFE;
    tick();
    dbus.dmem_ack_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b1 || dmem_error_o !== 1'b0 || valM_o !== 64'hCAFE) begin errors++; $display("FAIL tp_priority got wbv=%b err=%b m=%h exp 1/0/cafe", wb_valid_o, dmem_error_o, valM_o); end
  endtask

  task automatic test_back_to_back();
    valid_i = 1'b1; icode_i = 4'hA; valE_i = 64'h1F0; valA_i = 64'h11;
    tick();
    valid_i = 1'b0;
    checks++; if (dbus.dmem_wdata_o !== 64'h11 || dbus.dmem_addr_o !== 64'h1F0) begin errors++; $display("FAIL bb_push got wd=%h a=%h exp 11/1f0", dbus.dmem_wdata_o, dbus.dmem_addr_o); end
    dbus.dmem_ack_i = 1'b1;
    tick();
    dbus.dmem_ack_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b1 || ready_o !== 1'b1) begin errors++; $display("FAIL bb_retire got wbv=%b rdy=%b exp 1/1", wb_valid_o, ready_o); end
    valid_i = 1'b1; icode_i = 4'h5; valE_i = 64'h500;
    tick();
    valid_i = 1'b0;
    checks++; if (dbus.dmem_req_o !== 1'b1 || dbus.dmem_addr_o !== 64'h500 || dbus.dmem_we_o !== 1'b0 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL bb_second got req=%b a=%h we=%b wbv=%b exp 1/500/0/0", dbus.dmem_req_o, dbus.dmem_addr_o, dbus.dmem_we_o, wb_valid_o); end
    dbus.dmem_ack_i = 1'b1; dbus.dmem_rdata_i = 64'h77;
    tick();
    dbus.dmem_ack_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b1 || valM_o !== 64'h77 || valE_o !== 64'h500) begin errors++; $display("FAIL bb_read got wbv=%b m=%h e=%h exp 1/77/500", wb_valid_o, valM_o, valE_o); end
  endtask

  task automatic test_reset_busy();
    valid_i = 1'b1; icode_i = 4'h9; valE_i = 64'h408; valA_i = 64'h400;
    tick();
    valid_i = 1'b0;
    checks++; if (dbus.dmem_addr_o !== 64'h400 || dbus.dmem_req_o !== 1'b1) begin errors++; $display("FAIL rb_bus got a=%h req=%b exp 400/1", dbus.dmem_addr_o, dbus.dmem_req_o); end
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++; if (dbus.dmem_req_o !== 1'b0 || dbus.dmem_we_o !== 1'b0 || dbus.dmem_addr_o !== 64'h0 || dbus.dmem_wdata_o !== 64'h0) begin errors++; $display("FAIL rb_bus_clear got req=%b we=%b a=%h wd=%h exp 0", dbus.dmem_req_o, dbus.dmem_we_o, dbus.dmem_addr_o, dbus.dmem_wdata_o); end
    checks++; if (wb_valid_o !== 1'b0 || valE_o !== 64'h0 || valM_o !== 64'h0 || dmem_error_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL rb_out_clear got wbv=%b e=%h m=%h err=%b rdy=%b exp 0/0/0/0/1", wb_valid_o, valE_o, valM_o, dmem_error_o, ready_o); end
    dbus.dmem_ack_i = 1'b1; dbus.dmem_rdata_i = 64'hF00D;
    tick();
    dbus.dmem_ack_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b0 || valM_o !== 64'h0) begin errors++; $display("FAIL rb_ack_ignored got wbv=%b m=%h exp 0/0", wb_valid_o, valM_o); end
    tick();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL rb_no_retire got wbv=%b exp 0", wb_valid_o); end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_ack_idle();
    test_mrmovq();
    test_call();
    test_fault();
    test_timeout();
    test_ack_at_timeout();
    test_back_to_back();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
